// File: rtl/posit_decode_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// posit_pkg
//   Shared definitions for the posit decode scheduler slice: the scheduler
//   state encoding and helpers that derive field widths from the posit word
//   size N and exponent width es.
//   No ports (package).
// ---------------------------------------------------------------------------
package posit_pkg;

   // Scheduler states: wait for a request, pulse the extractor, copy its
   // registered fields, then hold the result until the consumer takes it.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_t;

   localparam int POSIT_N_DEFAULT  = 8;
   localparam int POSIT_ES_DEFAULT = 1;

   // Fraction bits left after sign, the shortest regime (2 bits) and es.
   function automatic int fracWidth(input int n, input int e);
      return n - e - 3;
   endfunction

   // Signed regime range is -(N-1)..(N-2), which needs clog2(N)+1 bits.
   function automatic int regimeWidth(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/posit_decode_scheduler_extraction.sv
// ---------------------------------------------------------------------------
// posit_extraction
//   Registered posit field extractor. When i_en is high the decoded fields of
//   i_posit are captured at the clock edge; when i_en is low the outputs
//   clear on the next edge, so a result is only visible for one cycle.
//   Ports:
//     i_clk, i_rst        clock, asynchronous active-high reset
//     i_en                capture enable
//     i_posit             posit word to decode
//     o_sign              sign bit
//     o_regime            regime value, two's complement
//     o_exponent          exponent field
//     o_fraction          fraction field, hidden bit excluded
//     o_abs_posit         two's complement magnitude of the word
//     o_zero, o_nar       special-value flags
// ---------------------------------------------------------------------------
module posit_extraction #(
   parameter  int N  = 8,
   parameter  int ES = 1,
   localparam int FW = N - ES - 3,
   localparam int RW = $clog2(N) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic [N-1:0]  i_posit,
   output logic          o_sign,
   output logic [RW-1:0] o_regime,
   output logic [ES-1:0] o_exponent,
   output logic [FW-1:0] o_fraction,
   output logic [N-1:0]  o_abs_posit,
   output logic          o_zero,
   output logic          o_nar
);

   logic          w_sign;
   logic [N-1:0]  w_abs;
   logic [N-2:0]  w_body;
   logic [N-2:0]  w_rest;
   logic          w_r;
   logic          w_stop;
   logic [RW-1:0] w_run;
   logic [RW-1:0] w_regime;

   // Decode the magnitude: measure the regime run starting just below the
   // sign, then shift out the run plus its terminating bit so the exponent
   // and fraction sit left-aligned in w_rest.
   always_comb begin
      w_sign = i_posit[N-1];
      w_abs  = w_sign ? (~i_posit + 1'b1) : i_posit;
      w_body = w_abs[N-2:0];
      w_r    = w_body[N-2];
      w_run  = '0;
      w_stop = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!w_stop && (w_body[i] == w_r)) begin
            w_run = w_run + 1'b1;
         end else begin
            w_stop = 1'b1;
         end
      end
      w_regime = w_r ? (w_run - 1'b1) : (~w_run + 1'b1);
      w_rest   = w_body << (w_run + 1'b1);
   end

   // Fields are registered only while enabled; otherwise they clear so the
   // consumer must copy them in the cycle after the enable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sign      <= 1'b0;
         o_regime    <= '0;
         o_exponent  <= '0;
         o_fraction  <= '0;
         o_abs_posit <= '0;
         o_zero      <= 1'b0;
         o_nar       <= 1'b0;
      end else if (i_en) begin
         o_sign      <= w_sign;
         o_regime    <= w_regime;
         o_exponent  <= w_rest[N-2 -: ES];
         o_fraction  <= w_rest[N-2-ES -: FW];
         o_abs_posit <= w_abs;
         o_zero      <= (i_posit == '0);
         o_nar       <= (i_posit == {1'b1, {(N-1){1'b0}}});
      end else begin
         o_sign      <= 1'b0;
         o_regime    <= '0;
         o_exponent  <= '0;
         o_fraction  <= '0;
         o_abs_posit <= '0;
         o_zero      <= 1'b0;
         o_nar       <= 1'b0;
      end
   end

endmodule

// File: rtl/posit_decode_scheduler.sv
// ---------------------------------------------------------------------------
// posit_decode_scheduler
//   Shares one posit_extraction unit between NUM_REQ requesters using
//   round-robin arbitration and returns each decoded result, tagged with the
//   owning requester id, through a single valid/ready output register.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     req_valid/req_ready per-requester handshake (req_ready one-hot or 0)
//     req_posit           flattened posit words, requester i at [i*N +: N]
//     out_valid/out_ready result handshake
//     out_id              requester that owns the result
//     out_sign .. out_nar decoded posit fields
//     busy                scheduler is not idle
// ---------------------------------------------------------------------------
module posit_decode_scheduler
   import posit_pkg::*;
#(
   parameter  int posit_width  = POSIT_N_DEFAULT,
   parameter  int es           = POSIT_ES_DEFAULT,
   parameter  int NUM_REQ      = 2,
   localparam int frac_width   = fracWidth(posit_width, es),
   localparam int regime_width = regimeWidth(posit_width),
   localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*posit_width-1:0] req_posit,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ID_W-1:0]                out_id,
   output logic                           out_sign,
   output logic [regime_width-1:0]        out_regime,
   output logic [es-1:0]                  out_exponent,
   output logic [frac_width-1:0]          out_fraction,
   output logic [posit_width-1:0]         out_abs_posit,
   output logic                           out_zero,
   output logic                           out_nar,
   output logic                           busy
);

   state_t                  r_state;
   logic [ID_W-1:0]         r_last_grant;
   logic [ID_W-1:0]         r_id;
   logic [posit_width-1:0]  r_posit;
   logic                    r_ext_en;

   logic [ID_W-1:0]         w_grant;
   logic                    w_found;
   logic                    w_accept;
   logic [posit_width-1:0]  w_grant_posit;
   int                      w_idx;

   logic                    w_ext_sign;
   logic [regime_width-1:0] w_ext_regime;
   logic [es-1:0]           w_ext_exponent;
   logic [frac_width-1:0]   w_ext_fraction;
   logic [posit_width-1:0]  w_ext_abs;
   logic                    w_ext_zero;
   logic                    w_ext_nar;

   // Round-robin search: first valid requester strictly after the last
   // grant, wrapping around, so the last winner has lowest priority.
   always_comb begin
      w_grant = r_last_grant;
      w_found = 1'b0;
      w_idx   = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         w_idx = (int'(r_last_grant) + off) % NUM_REQ;
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = ID_W'(w_idx);
         end
      end
   end

   // A request may only be taken when idle, or when the held result is
   // leaving this cycle (back-to-back path).
   always_comb begin
      w_accept      = w_found && ((r_state == IDLE) || ((r_state == OUT) && out_ready));
      w_grant_posit = req_posit[int'(w_grant)*posit_width +: posit_width];
      req_ready     = '0;
      if (w_accept) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   assign busy = (r_state != IDLE);

   posit_extraction #(
      .N  (posit_width),
      .ES (es)
   ) u_extract (
      .i_clk       (clk),
      .i_rst       (~reset_n),
      .i_en        (r_ext_en),
      .i_posit     (r_posit),
      .o_sign      (w_ext_sign),
      .o_regime    (w_ext_regime),
      .o_exponent  (w_ext_exponent),
      .o_fraction  (w_ext_fraction),
      .o_abs_posit (w_ext_abs),
      .o_zero      (w_ext_zero),
      .o_nar       (w_ext_nar)
   );

   // Scheduler FSM. The extractor enable is registered so it is high for
   // exactly the ISSUE cycle; the extractor fields are copied in CAPTURE
   // because they clear on the following edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_last_grant  <= ID_W'(NUM_REQ - 1);
         r_id          <= '0;
         r_posit       <= '0;
         r_ext_en      <= 1'b0;
         out_valid     <= 1'b0;
         out_id        <= '0;
         out_sign      <= 1'b0;
         out_regime    <= '0;
         out_exponent  <= '0;
         out_fraction  <= '0;
         out_abs_posit <= '0;
         out_zero      <= 1'b0;
         out_nar       <= 1'b0;
      end else begin
         r_ext_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_posit      <= w_grant_posit;
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  r_ext_en     <= 1'b1;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               r_state <= CAPTURE;
            end
            CAPTURE: begin
               out_sign      <= w_ext_sign;
               out_regime    <= w_ext_regime;
               out_exponent  <= w_ext_exponent;
               out_fraction  <= w_ext_fraction;
               out_abs_posit <= w_ext_abs;
               out_zero      <= w_ext_zero;
               out_nar       <= w_ext_nar;
               out_id        <= r_id;
               out_valid     <= 1'b1;
               r_state       <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (w_accept) begin
                     r_posit      <= w_grant_posit;
                     r_id         <= w_grant;
                     r_last_grant <= w_grant;
                     r_ext_en     <= 1'b1;
                     r_state      <= ISSUE;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_posit_decode_scheduler.sv
// ---------------------------------------------------------------------------
// tb_posit_decode_scheduler
//   Directed bench for posit_decode_scheduler with N=8, es=1, two requesters.
// ---------------------------------------------------------------------------
module tb_posit_decode_scheduler;

   logic        clk;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [15:0] req_posit;
   logic [1:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [0:0]  out_id;
   logic        out_sign;
   logic [3:0]  out_regime;
   logic [0:0]  out_exponent;
   logic [3:0]  out_fraction;
   logic [7:0]  out_abs_posit;
   logic        out_zero;
   logic        out_nar;
   logic        busy;

   int testCount = 0;
   int failCount = 0;

   posit_decode_scheduler #(
      .posit_width (8),
      .es          (1),
      .NUM_REQ     (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_posit     (req_posit),
      .req_ready     (req_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_id        (out_id),
      .out_sign      (out_sign),
      .out_regime    (out_regime),
      .out_exponent  (out_exponent),
      .out_fraction  (out_fraction),
      .out_abs_posit (out_abs_posit),
      .out_zero      (out_zero),
      .out_nar       (out_nar),
      .busy          (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive all request-side inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic [1:0] valid, input logic [7:0] p0,
                                input logic [7:0] p1, input logic ready);
      req_valid = valid;
      req_posit = {p1, p0};
      out_ready = ready;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Full result check in an OUT cycle.
   task automatic checkResult(input string tag, input logic id, input logic sign,
                              input logic [3:0] regime, input logic expo,
                              input logic [3:0] frac, input logic [7:0] absval,
                              input logic zero, input logic nar);
      checkOutput({tag, "_valid"},  32'(out_valid),     32'd1);
      checkOutput({tag, "_id"},     32'(out_id),        32'(id));
      checkOutput({tag, "_sign"},   32'(out_sign),      32'(sign));
      checkOutput({tag, "_regime"}, 32'(out_regime),    32'(regime));
      checkOutput({tag, "_exp"},    32'(out_exponent),  32'(expo));
      checkOutput({tag, "_frac"},   32'(out_fraction),  32'(frac));
      checkOutput({tag, "_abs"},    32'(out_abs_posit), 32'(absval));
      checkOutput({tag, "_zero"},   32'(out_zero),      32'(zero));
      checkOutput({tag, "_nar"},    32'(out_nar),       32'(nar));
   endtask

   initial begin
      reset_n   = 1'b1;
      req_valid = 2'b00;
      req_posit = 16'h0000;
      out_ready = 1'b0;
      #3 reset_n = 1'b0;
      tick();
      tick();

      // Reset state
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_busy",      32'(busy),      32'd0);
      checkOutput("rst_out_abs",   32'(out_abs_posit), 32'd0);
      reset_n = 1'b1;
      tick();

      // Requester 0 sends 0x40 (value 1.0): result three cycles after grant
      applyStimulus(2'b01, 8'h40, 8'h00, 1'b0);
      checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
      tick();
      applyStimulus(2'b00, 8'h40, 8'h00, 1'b0);
      checkOutput("t1_issue_busy",  32'(busy),      32'd1);
      checkOutput("t1_issue_ready", 32'(req_ready), 32'd0);
      checkOutput("t1_issue_valid", 32'(out_valid), 32'd0);
      tick();
      checkOutput("t1_capture_valid", 32'(out_valid), 32'd0);
      tick();
      checkResult("t1", 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h40, 1'b0, 1'b0);
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
      tick();
      checkOutput("t1_drain_valid", 32'(out_valid), 32'd0);
      checkOutput("t1_drain_busy",  32'(busy),      32'd0);

      // Requester 1 sends zero, then requester 0 sends NaR back-to-back
      applyStimulus(2'b10, 8'h00, 8'h00, 1'b0);
      checkOutput("t2_req_ready", 32'(req_ready), 32'h2);
      tick();
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      checkOutput("t2_zero_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_zero_flag",  32'(out_zero),  32'd1);
      checkOutput("t2_zero_nar",   32'(out_nar),   32'd0);
      checkOutput("t2_zero_id",    32'(out_id),    32'd1);
      applyStimulus(2'b01, 8'h80, 8'h00, 1'b1);
      checkOutput("t2_b2b_ready", 32'(req_ready), 32'h1);
      tick();
      applyStimulus(2'b00, 8'h80, 8'h00, 1'b0);
      checkOutput("t2_b2b_valid_drop", 32'(out_valid), 32'd0);
      tick();
      tick();
      checkOutput("t2_nar_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_nar_flag",  32'(out_nar),   32'd1);
      checkOutput("t2_nar_zero",  32'(out_zero),  32'd0);
      checkOutput("t2_nar_sign",  32'(out_sign),  32'd1);
      checkOutput("t2_nar_id",    32'(out_id),    32'd0);
      checkOutput("t2_nar_abs",   32'(out_abs_posit), 32'h80);
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
      tick();

      // Requester 1 sends 0x50 (value 2.0): regime 0, exponent 1
      applyStimulus(2'b10, 8'h00, 8'h50, 1'b0);
      checkOutput("t6_req_ready", 32'(req_ready), 32'h2);
      tick();
      applyStimulus(2'b00, 8'h00, 8'h50, 1'b0);
      tick();
      tick();
      checkResult("t6", 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 8'h50, 1'b0, 1'b0);
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
      tick();

      // Both requesters streaming with out_ready high: grants alternate
      applyStimulus(2'b11, 8'h40, 8'h50, 1'b1);
      checkOutput("t3_first_grant", 32'(req_ready), 32'h1);
      tick();
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t3_issue_ready_%0d", k), 32'(req_ready), 32'd0);
         tick();
         checkOutput($sformatf("t3_capture_ready_%0d", k), 32'(req_ready), 32'd0);
         checkOutput($sformatf("t3_capture_valid_%0d", k), 32'(out_valid), 32'd0);
         tick();
         checkOutput($sformatf("t3_out_valid_%0d", k), 32'(out_valid), 32'd1);
         checkOutput($sformatf("t3_out_id_%0d", k), 32'(out_id), 32'(k % 2));
         checkOutput($sformatf("t3_out_abs_%0d", k), 32'(out_abs_posit),
                     (k % 2 == 0) ? 32'h40 : 32'h50);
         checkOutput($sformatf("t3_regrant_%0d", k), 32'(req_ready),
                     (k % 2 == 0) ? 32'h2 : 32'h1);
         tick();
      end

      // Last grant (requester 0) runs to OUT and is then stalled 5 cycles
      applyStimulus(2'b00, 8'h40, 8'h50, 1'b0);
      tick();
      tick();
      applyStimulus(2'b01, 8'h40, 8'h50, 1'b0);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("t4_hold_valid_%0d", c), 32'(out_valid),     32'd1);
         checkOutput($sformatf("t4_hold_id_%0d", c),    32'(out_id),        32'd0);
         checkOutput($sformatf("t4_hold_abs_%0d", c),   32'(out_abs_posit), 32'h40);
         checkOutput($sformatf("t4_hold_ready_%0d", c), 32'(req_ready),     32'd0);
         checkOutput($sformatf("t4_hold_busy_%0d", c),  32'(busy),          32'd1);
         tick();
      end
      applyStimulus(2'b01, 8'h40, 8'h50, 1'b1);
      checkOutput("t4_release_regrant", 32'(req_ready), 32'h1);
      tick();
      applyStimulus(2'b00, 8'h40, 8'h50, 1'b0);
      checkOutput("t4_release_valid", 32'(out_valid), 32'd0);
      tick();

      // Reset pulse while in CAPTURE aborts the word; pointer restarts at 0
      reset_n = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("t5_rst_busy",  32'(busy),      32'd0);
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("t5_no_stale_%0d", c), 32'(out_valid), 32'd0);
      end
      applyStimulus(2'b11, 8'h40, 8'h50, 1'b0);
      checkOutput("t5_first_grant", 32'(req_ready), 32'h1);
      tick();
      applyStimulus(2'b00, 8'h40, 8'h50, 1'b0);
      tick();
      tick();
      checkResult("t5", 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h40, 1'b0, 1'b0);
      applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
      tick();
      checkOutput("t5_final_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
